// File: rtl/uart_regbank_burst_pkg.sv
// Shared ASCII constants, FSM encodings and hex conversion helpers for the
// UART register bank.
package uart_regbank_burst_pkg;

  localparam logic [7:0] ASC_W  = 8'h57;
  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_B  = 8'h42;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_QM = 8'h3F;
  localparam logic [7:0] ASC_EX = 8'h21;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADR,
    ST_DAT,
    ST_CNT,
    ST_EOL,
    ST_DISCARD,
    ST_EXEC_W,
    ST_RD_SEL,
    ST_RD_WAIT,
    ST_TX_HEX,
    ST_TX_EOL,
    ST_TX_ERR
  } state_e;

  typedef enum logic [1:0] {
    CMD_W,
    CMD_R,
    CMD_B
  } cmd_e;

  typedef enum logic [1:0] {
    REPLY_WORD,
    REPLY_ERR,
    REPLY_TMO
  } reply_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_dig_t;

  function automatic hex_dig_t hex2nib(input logic [7:0] c);
    hex_dig_t r;
    r.vld = 1'b1;
    r.nib = '0;
    if (c >= 8'h30 && c <= 8'h39) r.nib = c[3:0];
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) r.nib = c[3:0] + 4'd9;
    else r.vld = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_regbank_burst_ser.sv
// Serialises one reply (a hex word plus LF, or a two-byte code) over the
// request/acknowledge TX handshake; done pulses on the final acknowledge.
module uart_hex_word_ser
  import uart_regbank_burst_pkg::*;
#(
  parameter int unsigned C_DAT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  reply_e             code,
  input  logic [C_DAT_W-1:0] word,
  input  logic               tx_ack,
  output logic [7:0]         tx_byte,
  output logic               tx_req,
  output logic               eol,
  output logic               done
);

  localparam int unsigned DD = C_DAT_W / 4;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_REQ,
    SER_GAP
  } ser_e;

  ser_e               phase;
  logic [C_DAT_W-1:0] sh;
  logic [3:0]         left;
  logic               last;

  assign eol  = last;
  assign done = tx_req & tx_ack & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= SER_IDLE;
      sh      <= '0;
      left    <= '0;
      last    <= 1'b0;
      tx_byte <= '0;
      tx_req  <= 1'b0;
    end else begin
      unique case (phase)
        SER_IDLE: if (start) begin
          tx_req <= 1'b1;
          phase  <= SER_REQ;
          last   <= 1'b0;
          if (code == REPLY_WORD) begin
            tx_byte <= nib2hex(word[C_DAT_W-1 -: 4]);
            sh      <= word << 4;
            left    <= 4'(DD - 1);
          end else begin
            tx_byte <= (code == REPLY_TMO) ? ASC_EX : ASC_QM;
            sh      <= '0;
            left    <= '0;
          end
        end
        SER_REQ: if (tx_ack) begin
          tx_req <= 1'b0;
          if (last) begin
            last  <= 1'b0;
            phase <= SER_IDLE;
          end else begin
            phase <= SER_GAP;
          end
        end
        SER_GAP: begin
          // request stays low for this one cycle between bytes
          tx_req <= 1'b1;
          phase  <= SER_REQ;
          if (left != 4'd0) begin
            tx_byte <= nib2hex(sh[C_DAT_W-1 -: 4]);
            sh      <= sh << 4;
            left    <= left - 4'd1;
          end else begin
            tx_byte <= ASC_LF;
            last    <= 1'b1;
          end
        end
        default: phase <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_regbank_burst.sv
// ASCII-hex UART register bank: parses W/R/B command lines, updates or reads
// registers (RO ones via an external handshake) and streams hex replies.
module uart_regbank_burst
  import uart_regbank_burst_pkg::*;
#(
  parameter int unsigned                 C_DAT_W   = 16,
  parameter int unsigned                 C_ADR_W   = 8,
  parameter int unsigned                 C_REG_N   = 12,
  parameter logic [C_REG_N-1:0]          C_RO_MASK = '0,
  parameter logic [C_REG_N*C_DAT_W-1:0]  C_INIT    = '0,
  parameter int unsigned                 C_RD_TO   = 255
) (
  input  logic                         CK_i,
  input  logic                         XARST_i,
  input  logic [7:0]                   RX_BYTEs_i,
  input  logic                         RX_VLD_i,
  output logic [7:0]                   TX_BYTEs_o,
  output logic                         TX_REQ_o,
  input  logic                         TX_ACK_i,
  output logic [C_REG_N*C_DAT_W-1:0]   REGss_o,
  output logic [C_REG_N-1:0]           WT_STBs_o,
  output logic [C_ADR_W-1:0]           RD_ADRs_o,
  output logic                         RD_REQ_o,
  input  logic [C_REG_N*C_DAT_W-1:0]   RDATss_i,
  input  logic                         RD_ACK_i,
  output logic                         BUSY_o
);

  localparam int unsigned AD   = C_ADR_W / 4;
  localparam int unsigned DD   = C_DAT_W / 4;
  localparam int unsigned TO_W = $clog2(C_RD_TO + 1);

  state_e             state;
  cmd_e               cmd;
  logic [C_ADR_W-1:0] adr;
  logic [C_ADR_W-1:0] adr_nxt;
  logic [C_ADR_W-1:0] adr_wrap;
  logic [C_DAT_W-1:0] dat;
  logic [C_DAT_W-1:0] dat_nxt;
  logic [7:0]         cnt;
  logic [7:0]         cnt_nxt;
  logic [7:0]         rem;
  logic [3:0]         dig;
  logic               last_dig;
  logic               abort;
  logic [TO_W-1:0]    tmo_cnt;
  logic               rd_req;
  logic [C_ADR_W-1:0] rd_adr;
  logic [C_REG_N-1:0] wt_stb;
  logic [C_DAT_W-1:0] regs [C_REG_N];
  logic               ser_start;
  reply_e             ser_code;
  logic [C_DAT_W-1:0] ser_word;
  logic               ser_eol;
  logic               ser_done;
  hex_dig_t           hx;
  logic               adr_oor;
  logic               adr_is_ro;
  logic               nxt_is_ro;
  logic [C_DAT_W-1:0] rw_word;
  logic [C_DAT_W-1:0] ro_word;

  assign hx       = hex2nib(RX_BYTEs_i);
  assign adr_nxt  = C_ADR_W'({adr, hx.nib});
  assign dat_nxt  = C_DAT_W'({dat, hx.nib});
  assign cnt_nxt  = {cnt[3:0], hx.nib};
  assign adr_oor  = (32'(adr_nxt) >= 32'(C_REG_N));
  assign adr_wrap = (adr == C_ADR_W'(C_REG_N - 1)) ? '0 : adr + 1'b1;
  assign last_dig = (state == ST_ADR) ? (dig == 4'(AD - 1)) :
                    (state == ST_DAT) ? (dig == 4'(DD - 1)) : (dig == 4'd1);

  always_comb begin
    rw_word   = '0;
    ro_word   = '0;
    adr_is_ro = 1'b0;
    nxt_is_ro = 1'b0;
    REGss_o   = '0;
    for (int unsigned i = 0; i < C_REG_N; i++) begin
      if (adr == C_ADR_W'(i)) begin
        rw_word   = regs[i];
        ro_word   = RDATss_i[i*C_DAT_W +: C_DAT_W];
        adr_is_ro = C_RO_MASK[i];
      end
      if (adr_nxt == C_ADR_W'(i)) nxt_is_ro = C_RO_MASK[i];
      REGss_o[i*C_DAT_W +: C_DAT_W] = C_RO_MASK[i] ? '0 : regs[i];
    end
  end

  assign WT_STBs_o = wt_stb;
  assign RD_REQ_o  = rd_req;
  assign RD_ADRs_o = rd_adr;
  assign BUSY_o    = state inside {ST_EXEC_W, ST_RD_SEL, ST_RD_WAIT,
                                   ST_TX_HEX, ST_TX_EOL, ST_TX_ERR};

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state     <= ST_IDLE;
      cmd       <= CMD_R;
      adr       <= '0;
      dat       <= '0;
      cnt       <= '0;
      rem       <= '0;
      dig       <= '0;
      abort     <= 1'b0;
      tmo_cnt   <= '0;
      rd_req    <= 1'b0;
      rd_adr    <= '0;
      wt_stb    <= '0;
      ser_start <= 1'b0;
      ser_code  <= REPLY_WORD;
      ser_word  <= '0;
      for (int unsigned i = 0; i < C_REG_N; i++)
        regs[i] <= C_RO_MASK[i] ? '0 : C_INIT[i*C_DAT_W +: C_DAT_W];
    end else begin
      wt_stb    <= '0;
      ser_start <= 1'b0;
      unique case (state)
        ST_IDLE: if (RX_VLD_i) begin
          adr   <= '0;
          dat   <= '0;
          cnt   <= '0;
          dig   <= '0;
          abort <= 1'b0;
          if (RX_BYTEs_i == ASC_W) begin
            cmd   <= CMD_W;
            state <= ST_ADR;
          end else if (RX_BYTEs_i == ASC_R) begin
            cmd   <= CMD_R;
            state <= ST_ADR;
          end else if (RX_BYTEs_i == ASC_B) begin
            cmd   <= CMD_B;
            state <= ST_ADR;
          end else if (RX_BYTEs_i != ASC_CR && RX_BYTEs_i != ASC_LF) begin
            state <= ST_DISCARD;
          end
        end
        ST_ADR, ST_DAT, ST_CNT: if (RX_VLD_i && RX_BYTEs_i != ASC_CR) begin
          if (RX_BYTEs_i == ASC_LF) begin
            ser_code  <= REPLY_ERR;
            ser_start <= 1'b1;
            state     <= ST_TX_ERR;
          end else if (!hx.vld) begin
            state <= ST_DISCARD;
          end else begin
            dig <= last_dig ? '0 : dig + 4'd1;
            if (state == ST_ADR) begin
              adr <= adr_nxt;
              if (last_dig) begin
                if (adr_oor || (cmd == CMD_W && nxt_is_ro)) state <= ST_DISCARD;
                else if (cmd == CMD_W)                      state <= ST_DAT;
                else if (cmd == CMD_B)                      state <= ST_CNT;
                else                                        state <= ST_EOL;
              end
            end else if (state == ST_DAT) begin
              dat <= dat_nxt;
              if (last_dig) state <= ST_EOL;
            end else begin
              cnt <= cnt_nxt;
              if (last_dig) state <= ST_EOL;
            end
          end
        end
        ST_EOL: if (RX_VLD_i && RX_BYTEs_i != ASC_CR) begin
          if (RX_BYTEs_i != ASC_LF) begin
            state <= ST_DISCARD;
          end else if (cmd == CMD_W) begin
            // write lands on the LF edge; EXEC_W is only the busy slot after it
            for (int unsigned i = 0; i < C_REG_N; i++) begin
              if (adr == C_ADR_W'(i) && !C_RO_MASK[i]) begin
                regs[i]   <= dat;
                wt_stb[i] <= 1'b1;
              end
            end
            state <= ST_EXEC_W;
          end else begin
            rem   <= (cmd == CMD_B) ? cnt : '0;
            state <= ST_RD_SEL;
          end
        end
        ST_DISCARD: if (RX_VLD_i && RX_BYTEs_i == ASC_LF) begin
          ser_code  <= REPLY_ERR;
          ser_start <= 1'b1;
          state     <= ST_TX_ERR;
        end
        ST_EXEC_W: state <= ST_IDLE;
        ST_RD_SEL: begin
          if (adr_is_ro) begin
            rd_req  <= 1'b1;
            rd_adr  <= adr;
            tmo_cnt <= '0;
            state   <= ST_RD_WAIT;
          end else begin
            ser_word  <= rw_word;
            ser_code  <= REPLY_WORD;
            ser_start <= 1'b1;
            state     <= ST_TX_HEX;
          end
        end
        ST_RD_WAIT: begin
          if (RD_ACK_i) begin
            rd_req    <= 1'b0;
            ser_word  <= ro_word;
            ser_code  <= REPLY_WORD;
            ser_start <= 1'b1;
            state     <= ST_TX_HEX;
          end else if (tmo_cnt == TO_W'(C_RD_TO - 1)) begin
            rd_req    <= 1'b0;
            abort     <= 1'b1;
            ser_code  <= REPLY_TMO;
            ser_start <= 1'b1;
            state     <= ST_TX_HEX;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_TX_HEX, ST_TX_EOL: begin
          if (ser_done) begin
            if (!abort && rem != 8'd0) begin
              rem   <= rem - 8'd1;
              adr   <= adr_wrap;
              state <= ST_RD_SEL;
            end else begin
              state <= ST_IDLE;
            end
          end else if (ser_eol) begin
            state <= ST_TX_EOL;
          end
        end
        ST_TX_ERR: if (ser_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_hex_word_ser #(
    .C_DAT_W(C_DAT_W)
  ) u_ser (
    .clk    (CK_i),
    .rst_n  (XARST_i),
    .start  (ser_start),
    .code   (ser_code),
    .word   (ser_word),
    .tx_ack (TX_ACK_i),
    .tx_byte(TX_BYTEs_o),
    .tx_req (TX_REQ_o),
    .eol    (ser_eol),
    .done   (ser_done)
  );

endmodule
